// File: rtl/psum_accumulator_pkg.sv
// Shared controller parameters for the partial-sum accumulator.
// Holds lane/field widths, partial-sum RAM geometry and FSM state encodings.
// Imported by psum_accumulator and psum_ram users.
package psum_accumulator_pkg;

  localparam int Tout       = 4;
  localparam int W_PSUM     = 32;
  localparam int W_SIZE     = 8;
  localparam int W_CHANNEL  = 8;
  localparam int PSUM_DEPTH = 256;
  localparam int PSUM_AW    = 8;
  localparam int W_DATA     = Tout * W_PSUM;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } psum_state_e;

endpackage

// File: rtl/psum_ram.sv
// Simple dual-port (1R1W) synchronous read-first RAM holding partial sums.
// Ports: clk; rd_addr_i -> rd_data_o (one-cycle registered read);
//        wr_en_i/wr_addr_i/wr_data_i write port. No reset: contents persist.
module psum_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 128
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i
);

  logic [W-1:0] mem_q [DEPTH];

  // Read-first: a read and write to the same address on one edge returns
  // the old word; the accumulator forwards around this.
  always_ff @(posedge clk) begin
    rd_data_o <= mem_q[rd_addr_i];
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates per-pixel Tout-lane PE results across input-channel tiles in a
// partial-sum RAM and emits finished sums with row/col on the last tile.
// Ports: cfg_* latched by cfg_start in IDLE; i_* PE results (2-cycle latency,
//        1 pixel/cycle, no backpressure); o_* finished pixels, o_busy, o_done.
module psum_accumulator
  import psum_accumulator_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic [W_SIZE-1:0]    cfg_width,
  input  logic [PSUM_AW:0]     cfg_frame_size,
  input  logic [W_CHANNEL-1:0] cfg_q_channel,
  input  logic                 i_vld,
  input  logic [W_SIZE-1:0]    i_row,
  input  logic [W_SIZE-1:0]    i_col,
  input  logic [W_DATA-1:0]    i_acc_flat,
  output logic                 o_vld,
  output logic [W_SIZE-1:0]    o_row,
  output logic [W_SIZE-1:0]    o_col,
  output logic [W_DATA-1:0]    o_data_flat,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [PSUM_AW:0]     PIX_ONE  = 1;
  localparam logic [W_CHANNEL-1:0] TILE_ONE = 1;

  psum_state_e          state_q, state_d;
  logic [W_SIZE-1:0]    width_q, width_d;
  logic [PSUM_AW:0]     fsize_q, fsize_d;
  logic [W_CHANNEL-1:0] qch_q, qch_d;
  logic [PSUM_AW:0]     pix_cnt_q, pix_cnt_d;
  logic [W_CHANNEL-1:0] tile_cnt_q, tile_cnt_d;
  logic                 drain_q, drain_d;

  logic                 accept, pix_last, tile_last;
  logic [PSUM_AW-1:0]   s1_addr_d;

  // S1 registers (pixel whose RAM read is in flight)
  logic                 s1_vld_q, s1_first_q, s1_last_q;
  logic [PSUM_AW-1:0]   s1_addr_q;
  logic [W_SIZE-1:0]    s1_row_q, s1_col_q;
  logic [W_DATA-1:0]    s1_acc_q;
  logic                 fwd_q;
  logic [W_DATA-1:0]    fwd_dat_q;

  logic [W_DATA-1:0]    ram_rd_dat, base, sum;
  logic                 s2_wr_en;

  logic                 o_vld_q;
  logic [W_SIZE-1:0]    o_row_q, o_col_q;
  logic [W_DATA-1:0]    o_data_q;

  assign accept    = (state_q == ST_ACC) && i_vld;
  assign pix_last  = (pix_cnt_q == fsize_q - PIX_ONE);
  assign tile_last = (tile_cnt_q == qch_q - TILE_ONE);
  // Computed in PSUM_AW bits so the address wraps for out-of-range coordinates.
  assign s1_addr_d = PSUM_AW'(i_row) * PSUM_AW'(width_q) + PSUM_AW'(i_col);

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    fsize_d    = fsize_q;
    qch_d      = qch_q;
    pix_cnt_d  = pix_cnt_q;
    tile_cnt_d = tile_cnt_q;
    drain_d    = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d    = ST_ACC;
          width_d    = cfg_width;
          fsize_d    = cfg_frame_size;
          qch_d      = cfg_q_channel;
          pix_cnt_d  = '0;
          tile_cnt_d = '0;
        end
      end
      ST_ACC: begin
        if (accept) begin
          if (pix_last) begin
            pix_cnt_d  = '0;
            tile_cnt_d = tile_cnt_q + TILE_ONE;
            if (tile_last) begin
              state_d = ST_DRAIN;
              drain_d = 1'b0;
            end
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_ONE;
          end
        end
      end
      ST_DRAIN: begin
        // Two cycles lets the final pixel leave S2 before returning to IDLE.
        if (drain_q) begin
          state_d = ST_IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      width_q    <= '0;
      fsize_q    <= '0;
      qch_q      <= '0;
      pix_cnt_q  <= '0;
      tile_cnt_q <= '0;
      drain_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      fsize_q    <= fsize_d;
      qch_q      <= qch_d;
      pix_cnt_q  <= pix_cnt_d;
      tile_cnt_q <= tile_cnt_d;
      drain_q    <= drain_d;
    end
  end

  psum_ram #(
    .DEPTH (PSUM_DEPTH),
    .AW    (PSUM_AW),
    .W     (W_DATA)
  ) u_ram (
    .clk       (clk),
    .rd_addr_i (s1_addr_d),
    .rd_data_o (ram_rd_dat),
    .wr_en_i   (s2_wr_en),
    .wr_addr_i (s1_addr_q),
    .wr_data_i (sum)
  );

  assign s2_wr_en = s1_vld_q && !s1_last_q;

  // The RAM is read-first, so a read on the same edge as a write to the same
  // address would see the stale word; capture the sum being written instead.
  always_comb begin
    base = s1_first_q ? '0 : (fwd_q ? fwd_dat_q : ram_rd_dat);
    sum  = '0;
    for (int g = 0; g < Tout; g++) begin
      sum[g*W_PSUM +: W_PSUM] = base[g*W_PSUM +: W_PSUM] + s1_acc_q[g*W_PSUM +: W_PSUM];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      s1_acc_q   <= '0;
      fwd_q      <= 1'b0;
      fwd_dat_q  <= '0;
      o_vld_q    <= 1'b0;
      o_row_q    <= '0;
      o_col_q    <= '0;
      o_data_q   <= '0;
    end else begin
      s1_vld_q  <= accept;
      fwd_q     <= accept && s2_wr_en && (s1_addr_q == s1_addr_d);
      fwd_dat_q <= sum;
      if (accept) begin
        s1_first_q <= (tile_cnt_q == '0);
        s1_last_q  <= tile_last;
        s1_addr_q  <= s1_addr_d;
        s1_row_q   <= i_row;
        s1_col_q   <= i_col;
        s1_acc_q   <= i_acc_flat;
      end
      o_vld_q <= s1_vld_q && s1_last_q;
      if (s1_vld_q && s1_last_q) begin
        o_row_q  <= s1_row_q;
        o_col_q  <= s1_col_q;
        o_data_q <= sum;
      end
    end
  end

  assign o_vld       = o_vld_q;
  assign o_row       = o_row_q;
  assign o_col       = o_col_q;
  assign o_data_flat = o_data_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DRAIN) && drain_q;

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Downstream of the PE engine. Takes the per-pixel Tout-lane conv results and accumulates them across the input-channel tiles of one output frame in an on-chip partial-sum RAM. On the last tile it emits the finished Tout-lane sums, with their row/col, to the post-processing stage. It replaces the debug partial-sum array inside the PE engine.

## Interface
- Tout, 4, output-channel lanes per pixel
- W_PSUM, 32, bits per lane (two's complement)
- W_SIZE, 8, row/col/width field width
- W_CHANNEL, 8, tile-count field width
- PSUM_DEPTH, 256, pixel entries in the partial-sum RAM
- PSUM_AW, 8, RAM address width, log2(PSUM_DEPTH)
- clk  in  1  single clock; everything is on the rising edge
- rst  in  1  reset, synchronous and active-high
- cfg_start  in  1  one-cycle pulse that latches the cfg_* inputs; honoured only in IDLE
- cfg_width  in  W_SIZE  output frame width in pixels
- cfg_frame_size  in  PSUM_AW+1  pixels per tile (width*height); must be ≥1 and ≤PSUM_DEPTH
- cfg_q_channel  in  W_CHANNEL  input-channel tiles to accumulate; must be ≥1
- i_vld  in  1  one PE result this cycle
- i_row, i_col  in  W_SIZE each  pixel coordinate of the result
- i_acc_flat  in  Tout*W_PSUM  lane g is at bits [(g+1)*W_PSUM-1 -: W_PSUM]
- o_vld  out  1  finished pixel valid; there is no backpressure
- o_row, o_col  out  W_SIZE each  coordinate of the finished pixel
- o_data_flat  out  Tout*W_PSUM  finished sums, same packing as i_acc_flat
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the frame is complete

## Operation
- FSM states: IDLE, ACC, DRAIN.
  - IDLE → ACC on cfg_start: latch cfg, clear pix_cnt and tile_cnt.
  - ACC → DRAIN when the last pixel of the last tile is accepted.
  - DRAIN → IDLE after 2 cycles, once the pipeline is empty. o_done is asserted in the final DRAIN cycle.
- i_vld is accepted only in ACC. It is ignored in IDLE and DRAIN. cfg_start outside IDLE is ignored.
- Address: addr = i_row*cfg_width + i_col, truncated to PSUM_AW bits. Out-of-range coordinates are caller error: the address wraps and there is no check.
- Counting on each accepted pixel:
  - pix_cnt increments.
  - At cfg_frame_size-1, pix_cnt wraps to 0 and tile_cnt increments.
  - The last tile is tile_cnt == cfg_q_channel-1.
- Each pixel carries two flags: first = (tile_cnt==0), last = last tile.
- Per pixel and per lane:
  - sum = (first ? 0 : ram[addr]) + acc, wrapping modulo 2^W_PSUM with no saturation.
  - If not last: ram[addr] ← sum.
  - If last: no RAM write; sum goes to the output.
  - cfg_q_channel==1 is both first and last, so the output is acc unchanged and the RAM is never touched.
- The RAM is never cleared. Tile 0 overwrites every entry, so stale contents from an earlier frame never reach an output.
- Reset, including mid-frame: FSM→IDLE; counters and pipeline valids cleared; o_vld, o_busy, o_done, o_row, o_col, o_data_flat all 0. RAM contents are left unchanged. The next frame starts cleanly.

## Timing
- Pipeline S1 (cycle t, i_vld sampled): compute the address; register addr/acc/flags/row/col; present the RAM read address at the t edge.
- Pipeline S2 (cycle t+1): RAM read data is valid (synchronous, read-first); compute the sum; write the RAM and/or the output registers at the t+1 edge.
- o_vld is high in cycle t+2. Latency is fixed at 2 cycles. Full throughput is one pixel per cycle.
- Hazard: if the S1 address equals the address S2 writes on the same edge, S1 takes the S2 sum (forwarded) instead of RAM data. This covers back-to-back same-address writes and frame_size==1.
- o_done goes high 2 cycles after the last pixel is accepted, in the same cycle as that pixel's o_vld. o_busy drops the following cycle.

## Structure
- Add to the shared controller params header: PSUM_DEPTH, PSUM_AW, and the FSM state encodings (2 bits).
- One sub-module, psum_ram: a simple dual-port (1R1W) synchronous, read-first RAM of depth PSUM_DEPTH and width Tout*W_PSUM. Forwarding lives in psum_accumulator, not in the RAM.

## Test plan
- Single tile: cfg_q_channel=1, frame 4x4; the pixel at (1,2) has lanes {1,2,3,4} → o_vld 2 cycles later with (1,2) and lanes {1,2,3,4}. o_done on the 16th output. No RAM writes.
- Three tiles: frame 4x4; every pixel gets lanes {10,-3,0x7FFFFFFF,5} per tile → 16 outputs, each {30,-9,0x7FFFFFFD,15} (lane 2 wraps). Outputs appear only during tile 2.
- Forwarding: frame_size=1, q_channel=4, i_vld on 4 consecutive cycles with acc=1 on all lanes → a single output with all lanes = 4.
- Mid-frame reset: rst asserted for 1 cycle during tile 1. All outputs 0 next cycle. Then a fresh 2-tile frame of constant 7 → all outputs 14, with no contamination from the earlier frame.
- Ignored inputs: i_vld in IDLE, and cfg_start during ACC → no o_vld, tile count unchanged, original cfg kept.
- Stale RAM: frame A (2 tiles, acc=100), then frame B (2 tiles, acc=1) → B outputs are 2, not 102.
